// File: rtl/register_bank_fwd_if.sv
// Decode-stage operand bus: read addresses, per-stage forwarding sources and WB
// write port in; registered operands and forwarding codes out.
interface register_bank_fwd_if #(
  parameter int DATA_W = 16,
  parameter int ADDR_W = 5
);
  logic              stall;
  logic              flush;
  logic [ADDR_W-1:0] RA;
  logic [ADDR_W-1:0] RB;
  logic [DATA_W-1:0] imm;
  logic              imm_sel;
  logic              ex_we;
  logic [ADDR_W-1:0] RW_ex;
  logic [DATA_W-1:0] ans_ex;
  logic              dm_we;
  logic [ADDR_W-1:0] RW_dm;
  logic [DATA_W-1:0] ans_dm;
  logic              wb_we;
  logic [ADDR_W-1:0] RW_wb;
  logic [DATA_W-1:0] ans_wb;
  logic [DATA_W-1:0] A;
  logic [DATA_W-1:0] B;
  logic [1:0]        fwd_A;
  logic [1:0]        fwd_B;

  modport master (
    output stall, flush, RA, RB, imm, imm_sel,
           ex_we, RW_ex, ans_ex, dm_we, RW_dm, ans_dm, wb_we, RW_wb, ans_wb,
    input  A, B, fwd_A, fwd_B
  );

  modport slave (
    input  stall, flush, RA, RB, imm, imm_sel,
           ex_we, RW_ex, ans_ex, dm_we, RW_dm, ans_dm, wb_we, RW_wb, ans_wb,
    output A, B, fwd_A, fwd_B
  );
endinterface

// File: rtl/register_bank_fwd.sv
// Decode-stage register file with automatic EX/DM/WB forwarding; both operands
// are resolved per lane and registered into the decode/execute boundary.

module register_bank_fwd_lane #(
  parameter int DATA_W   = 16,
  parameter int ADDR_W   = 5,
  parameter int ZERO_REG = 1
) (
  input  logic [ADDR_W-1:0] addr_i,
  input  logic [DATA_W-1:0] file_i,
  input  logic              ex_we_i,
  input  logic [ADDR_W-1:0] rw_ex_i,
  input  logic [DATA_W-1:0] ans_ex_i,
  input  logic              dm_we_i,
  input  logic [ADDR_W-1:0] rw_dm_i,
  input  logic [DATA_W-1:0] ans_dm_i,
  input  logic              wb_we_i,
  input  logic [ADDR_W-1:0] rw_wb_i,
  input  logic [DATA_W-1:0] ans_wb_i,
  output logic [DATA_W-1:0] val_o,
  output logic [1:0]        fwd_o
);
  logic zero_hit;
  assign zero_hit = (ZERO_REG != 0) && (addr_i == '0);

  // Youngest producer wins: EX > DM > WB > file.
  always_comb begin
    val_o = file_i;
    fwd_o = 2'b00;
    if (zero_hit) begin
      val_o = '0;
    end else if (ex_we_i && rw_ex_i == addr_i) begin
      val_o = ans_ex_i;
      fwd_o = 2'b01;
    end else if (dm_we_i && rw_dm_i == addr_i) begin
      val_o = ans_dm_i;
      fwd_o = 2'b10;
    end else if (wb_we_i && rw_wb_i == addr_i) begin
      val_o = ans_wb_i;
      fwd_o = 2'b11;
    end
  end
endmodule

module register_bank_fwd #(
  parameter int DATA_W   = 16,
  parameter int ADDR_W   = 5,
  parameter int ZERO_REG = 1
) (
  input  logic                clk,
  input  logic                rst_n,
  register_bank_fwd_if.slave  bus
);
  localparam int DEPTH     = 1 << ADDR_W;
  localparam int NUM_LANES = 2;

  logic [DEPTH-1:0][DATA_W-1:0]     regs_q;
  logic [NUM_LANES-1:0][ADDR_W-1:0] rd_addr;
  logic [NUM_LANES-1:0][DATA_W-1:0] rd_file;
  logic [NUM_LANES-1:0][DATA_W-1:0] rd_val;
  logic [NUM_LANES-1:0][1:0]        rd_fwd;
  logic                             wr_en;

  logic [DATA_W-1:0] a_q, a_d, b_q, b_d;
  logic [1:0]        fwd_a_q, fwd_a_d, fwd_b_q, fwd_b_d;

  assign rd_addr[0] = bus.RA;
  assign rd_addr[1] = bus.RB;

  for (genvar l = 0; l < NUM_LANES; l++) begin : g_lane
    assign rd_file[l] = regs_q[rd_addr[l]];
    register_bank_fwd_lane #(
      .DATA_W(DATA_W), .ADDR_W(ADDR_W), .ZERO_REG(ZERO_REG)
    ) u_lane (
      .addr_i  (rd_addr[l]),
      .file_i  (rd_file[l]),
      .ex_we_i (bus.ex_we), .rw_ex_i(bus.RW_ex), .ans_ex_i(bus.ans_ex),
      .dm_we_i (bus.dm_we), .rw_dm_i(bus.RW_dm), .ans_dm_i(bus.ans_dm),
      .wb_we_i (bus.wb_we), .rw_wb_i(bus.RW_wb), .ans_wb_i(bus.ans_wb),
      .val_o   (rd_val[l]),
      .fwd_o   (rd_fwd[l])
    );
  end

  assign wr_en = bus.wb_we && !((ZERO_REG != 0) && (bus.RW_wb == '0));

  // File writes ignore stall/flush so WB retires while decode is frozen.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) regs_q <= '0;
    else if (wr_en) regs_q[bus.RW_wb] <= bus.ans_wb;
  end

  always_comb begin
    a_d     = a_q;
    b_d     = b_q;
    fwd_a_d = fwd_a_q;
    fwd_b_d = fwd_b_q;
    if (bus.flush) begin
      a_d     = '0;
      b_d     = '0;
      fwd_a_d = 2'b00;
      fwd_b_d = 2'b00;
    end else if (!bus.stall) begin
      a_d     = rd_val[0];
      fwd_a_d = rd_fwd[0];
      b_d     = bus.imm_sel ? bus.imm : rd_val[1];
      fwd_b_d = bus.imm_sel ? 2'b00   : rd_fwd[1];
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      a_q     <= '0;
      b_q     <= '0;
      fwd_a_q <= 2'b00;
      fwd_b_q <= 2'b00;
    end else begin
      a_q     <= a_d;
      b_q     <= b_d;
      fwd_a_q <= fwd_a_d;
      fwd_b_q <= fwd_b_d;
    end
  end

  assign bus.A     = a_q;
  assign bus.B     = b_q;
  assign bus.fwd_A = fwd_a_q;
  assign bus.fwd_B = fwd_b_q;
endmodule

// File: tb/tb_register_bank_fwd.sv
// Directed bench: a ZERO_REG=1 and a ZERO_REG=0 instance share one stimulus.
module tb_register_bank_fwd;
  logic clk = 1'b0;
  logic rst_n;
  int   errs = 0;
  int   checks = 0;

  always #5 clk = ~clk;

  register_bank_fwd_if #(.DATA_W(16), .ADDR_W(5)) bus ();
  register_bank_fwd_if #(.DATA_W(16), .ADDR_W(5)) bus_nz ();

  assign bus_nz.stall   = bus.stall;
  assign bus_nz.flush   = bus.flush;
  assign bus_nz.RA      = bus.RA;
  assign bus_nz.RB      = bus.RB;
  assign bus_nz.imm     = bus.imm;
  assign bus_nz.imm_sel = bus.imm_sel;
  assign bus_nz.ex_we   = bus.ex_we;
  assign bus_nz.RW_ex   = bus.RW_ex;
  assign bus_nz.ans_ex  = bus.ans_ex;
  assign bus_nz.dm_we   = bus.dm_we;
  assign bus_nz.RW_dm   = bus.RW_dm;
  assign bus_nz.ans_dm  = bus.ans_dm;
  assign bus_nz.wb_we   = bus.wb_we;
  assign bus_nz.RW_wb   = bus.RW_wb;
  assign bus_nz.ans_wb  = bus.ans_wb;

  register_bank_fwd #(.DATA_W(16), .ADDR_W(5), .ZERO_REG(1))
    u_dut (.clk(clk), .rst_n(rst_n), .bus(bus));
  register_bank_fwd #(.DATA_W(16), .ADDR_W(5), .ZERO_REG(0))
    u_dut_nz (.clk(clk), .rst_n(rst_n), .bus(bus_nz));

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errs++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic idle();
    bus.stall = 0; bus.flush = 0; bus.RA = '0; bus.RB = '0;
    bus.imm = '0; bus.imm_sel = 0;
    bus.ex_we = 0; bus.RW_ex = '0; bus.ans_ex = '0;
    bus.dm_we = 0; bus.RW_dm = '0; bus.ans_dm = '0;
    bus.wb_we = 0; bus.RW_wb = '0; bus.ans_wb = '0;
  endtask

  initial begin
    idle();
    rst_n = 1'b1;
    #2 rst_n = 1'b0;
    tick(); tick();
    rst_n = 1'b1;

    // async reset mid-cycle
    bus.ex_we = 1; bus.RW_ex = 5'd9; bus.ans_ex = 16'h1234; bus.RA = 5'd9; bus.RB = 5'd9;
    tick();
    chk("load_A", bus.A, 16'h1234);
    chk("load_fwdA", bus.fwd_A, 2'b01);
    #2 rst_n = 1'b0;
    #1;
    chk("rst_A", bus.A, 0);
    chk("rst_B", bus.B, 0);
    chk("rst_fwdA", bus.fwd_A, 0);
    chk("rst_fwdB", bus.fwd_B, 0);
    idle();
    bus.wb_we = 1; bus.RW_wb = 5'd5; bus.ans_wb = 16'hAAAA;
    tick();
    chk("rst_hold_A", bus.A, 0);
    rst_n = 1'b1;
    idle();
    bus.RA = 5'd5;
    tick();
    chk("r5_after_rst", bus.A, 0);
    chk("r5_after_rst_fwd", bus.fwd_A, 0);

    // WB write with same-cycle bypass, then plain file read
    idle();
    bus.wb_we = 1; bus.RW_wb = 5'd7; bus.ans_wb = 16'hE000; bus.RA = 5'd7;
    tick();
    chk("wb_bypass_A", bus.A, 16'hE000);
    chk("wb_bypass_fwd", bus.fwd_A, 2'b11);
    idle();
    bus.RA = 5'd7;
    tick();
    chk("file_A", bus.A, 16'hE000);
    chk("file_fwd", bus.fwd_A, 2'b00);

    // priority EX > DM > WB
    bus.RA = 5'd5; bus.RB = 5'd5;
    bus.ex_we = 1; bus.RW_ex = 5'd5; bus.ans_ex = 16'hC000;
    bus.dm_we = 1; bus.RW_dm = 5'd5; bus.ans_dm = 16'hD000;
    bus.wb_we = 1; bus.RW_wb = 5'd5; bus.ans_wb = 16'hE000;
    tick();
    chk("pri_ex_A", bus.A, 16'hC000);
    chk("pri_ex_B", bus.B, 16'hC000);
    chk("pri_ex_fwdA", bus.fwd_A, 2'b01);
    chk("pri_ex_fwdB", bus.fwd_B, 2'b01);
    bus.ex_we = 0;
    tick();
    chk("pri_dm_A", bus.A, 16'hD000);
    chk("pri_dm_fwdA", bus.fwd_A, 2'b10);
    chk("pri_dm_fwdB", bus.fwd_B, 2'b10);
    bus.dm_we = 0;
    tick();
    chk("pri_wb_A", bus.A, 16'hE000);
    chk("pri_wb_fwdA", bus.fwd_A, 2'b11);

    // immediate on B, A reads r7 from file
    idle();
    bus.imm = 16'hFFFF; bus.imm_sel = 1; bus.RB = 5'd6; bus.RA = 5'd7;
    bus.dm_we = 1; bus.RW_dm = 5'd6; bus.ans_dm = 16'h1111;
    tick();
    chk("imm_B", bus.B, 16'hFFFF);
    chk("imm_fwdB", bus.fwd_B, 2'b00);
    chk("imm_A", bus.A, 16'hE000);
    chk("imm_fwdA", bus.fwd_A, 2'b00);

    // register 0: hardwired vs ordinary
    idle();
    bus.wb_we = 1; bus.RW_wb = 5'd0; bus.ans_wb = 16'hBEEF;
    bus.ex_we = 1; bus.RW_ex = 5'd0; bus.ans_ex = 16'hC000;
    tick();
    chk("zr_A", bus.A, 0);
    chk("zr_fwdA", bus.fwd_A, 2'b00);
    chk("nz_A", bus_nz.A, 16'hC000);
    chk("nz_fwdA", bus_nz.fwd_A, 2'b01);
    idle();
    tick();
    chk("zr_file_A", bus.A, 0);
    chk("nz_file_A", bus_nz.A, 16'hBEEF);

    // stall holds while the file keeps accepting writes
    idle();
    bus.ex_we = 1; bus.RW_ex = 5'd9; bus.ans_ex = 16'hC000; bus.RA = 5'd9;
    tick();
    chk("st_load_A", bus.A, 16'hC000);
    bus.stall = 1;
    bus.ans_ex = 16'h1234;
    bus.wb_we = 1; bus.RW_wb = 5'd3; bus.ans_wb = 16'h3333;
    tick();
    chk("st1_A", bus.A, 16'hC000);
    bus.wb_we = 0; bus.ans_ex = 16'h5678;
    tick();
    chk("st2_A", bus.A, 16'hC000);
    bus.ans_ex = 16'h9ABC;
    tick();
    chk("st3_A", bus.A, 16'hC000);
    chk("st3_fwdA", bus.fwd_A, 2'b01);
    idle();
    bus.RA = 5'd3; bus.RB = 5'd3;
    tick();
    chk("st_wb_A", bus.A, 16'h3333);
    chk("st_wb_fwdA", bus.fwd_A, 2'b00);
    bus.stall = 1; bus.flush = 1;
    tick();
    chk("fl_A", bus.A, 0);
    chk("fl_B", bus.B, 0);
    chk("fl_fwdA", bus.fwd_A, 0);

    $display("Result: errors=%0d of %0d checks", errs, checks);
    $finish;
  end

  initial begin
    #20000;
    $display("FAIL timeout got=running exp=done");
    $fatal(1);
  end
endmodule

// File: doc/register_bank_fwd.md
# register_bank_fwd

Parametrised successor to the 16-bit, 32-entry register bank in the decode stage. Holds the architectural register file and resolves both read operands, with one write port fed from write-back. It automatically selects the youngest in-flight result from the EX, DM or WB stage, using per-stage write-enable and destination-address comparison instead of externally supplied mux selects. Operands are registered into the decode/execute boundary, with stall, flush and optional hardwired-zero register 0.

## Interface
- DATA_W, 16: operand/register width in bits
- ADDR_W, 5: register address width; depth = 2**ADDR_W
- ZERO_REG, 1: when 1, register 0 reads as 0, is never a forwarding match, and ignores writes

- clk  in  1  rising-edge clock
- rst_n  in  1  asynchronous, active-low reset
- stall  in  1  hold A/B/fwd outputs
- flush  in  1  clear A/B/fwd outputs (bubble)
- RA  in  ADDR_W  operand A source register
- RB  in  ADDR_W  operand B source register
- imm  in  DATA_W  immediate for operand B
- imm_sel  in  1  1: B takes imm
- ex_we  in  1  EX-stage result will write a register
- RW_ex  in  ADDR_W  EX destination
- ans_ex  in  DATA_W  EX result
- dm_we  in  1  DM-stage valid write
- RW_dm  in  ADDR_W  DM destination
- ans_dm  in  DATA_W  DM result
- wb_we  in  1  WB write enable (also the register-file write port)
- RW_wb  in  ADDR_W  WB destination
- ans_wb  in  DATA_W  WB data
- A  out  DATA_W  registered operand A
- B  out  DATA_W  registered operand B
- fwd_A  out  2  source of A: 00 file, 01 EX, 10 DM, 11 WB
- fwd_B  out  2  source of B, same coding; 00 when imm_sel

## Operation
- Per-operand resolution (combinational, for addr = RA or RB):
  - A stage matches when its we=1 and its RW == addr.
  - With ZERO_REG=1 and addr==0, nothing matches and the value is 0.
  - Priority is EX > DM > WB > register file.
- Next B is imm when imm_sel=1, otherwise the resolved RB value.
- Output update at each posedge, in priority order:
  - flush=1: A, B, fwd_A, fwd_B <= 0. Flush overrides stall.
  - Otherwise stall=1: all four outputs hold.
  - Otherwise: the outputs load the resolved values and codes.
- Register-file write:
  - At posedge, when wb_we=1, regs[RW_wb] <= ans_wb.
  - The write is suppressed for RW_wb==0 when ZERO_REG=1.
  - The write is independent of stall and flush.
- Same-cycle WB write and read of the same register: A/B receive ans_wb through the WB bypass (fwd=11), never the old file contents.
- Address and data widths are exact; no sign extension. Any imm extension is done upstream.

## Timing
- Latency: RA/RB/imm/forwarding inputs in cycle N appear on A/B after the posedge ending cycle N (1 cycle).
- Reset (rst_n=0, asynchronous):
  - Every register entry, A, B, fwd_A and fwd_B go to 0 immediately.
  - No write occurs while rst_n=0.
  - Deassertion takes effect at the next posedge.
- Reset mid-operation: a pending WB write in the reset cycle is lost. Outputs stay 0 until the first posedge with rst_n=1.
- Stall spanning several cycles:
  - Outputs are frozen, and the file keeps accepting WB writes.
  - Pipeline control guarantees held operands remain valid.
- Multiple stages writing the same register: only the highest-priority value is used; lower stages are ignored.
- All ports beyond the output registers are combinational-to-register; there are no combinational paths from inputs to outputs.

## Test plan
- Reset: assert rst_n=0 mid-cycle with A=16'h1234 -> A, B, fwd_A, fwd_B = 0 without a clock edge. Reads of r5 after release return 0.
- File write/read:
  - WB writes r7=16'hE000 with no other stage matching; next cycle RA=7 -> A=16'hE000, fwd_A=00 (bypass off).
  - Same-cycle RA=7 while writing -> A=16'hE000, fwd_A=11.
- Priority: ex, dm and wb all writing r5 with ans_ex=16'hC000, ans_dm=16'hD000, ans_wb=16'hE000, RA=RB=5 -> A=B=16'hC000, fwd=01.
  - Drop ex_we -> A=16'hD000, fwd=10.
  - Drop dm_we -> A=16'hE000, fwd=11.
- Immediate: imm=16'hFFFF, imm_sel=1, RB=6 with dm matching -> B=16'hFFFF, fwd_B=00. A is unaffected.
- Zero register: ZERO_REG=1, WB writes r0=16'hBEEF, EX targets r0 with 16'hC000, RA=0 -> A=0, fwd_A=00.
  - ZERO_REG=0 build, same stimulus -> A=16'hC000.
- Stall/flush: load A=16'hC000, then stall=1 for 3 cycles while ans_ex changes -> A holds 16'hC000.
  - A WB write to r3 during the stall is visible afterwards.
  - flush=1 together with stall=1 -> A=B=0 next edge.
